// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner:
// the active-low hex decode table, blank patterns, digit count and slot states.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  // Bit order a,b,c,d,e,f,g,dp; dp is held off (1) here and driven separately.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h61, 8'h85, 8'hE5, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_st_e;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment decoder (dp bit left off).
module hex7seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed seven-segment driver with frame-synchronous display
// updates and leading-zero blanking; seg_out/dig_out are registered (1 clk latency).
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_we,
  input  logic        lzb_en,
  output logic [7:0]  seg_out,
  output logic [3:0]  dig_out,
  output logic        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  scan_st_e      state_q, state_d;
  logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic          pend_q, pend_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic          tick_q, tick_d;

  logic          cnt_wrap, frame_end;
  logic [3:0]    cur_nib;
  logic [7:0]    dec_seg;
  logic [15:0]   upper;
  logic          lead_zero;

  hex7seg_dec u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_wrap  = (cnt_q == CNT_LAST);
    frame_end = cnt_wrap && (dig_q == DIG_LAST);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    dig_d     = cnt_wrap ? dig_q + 1'b1 : dig_q;
    // Slot state tracks the counter value it will hold after this edge.
    state_d   = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
  end

  // Display register only moves at the frame boundary; a coincident write bypasses the shadow.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    tick_d      = 1'b0;
    if (frame_end && value_we) begin
      disp_d    = value_in;
      disp_dp_d = dp_in;
      pend_d    = 1'b0;
      tick_d    = 1'b1;
    end else if (frame_end && pend_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pend_d    = 1'b0;
      tick_d    = 1'b1;
    end else if (value_we) begin
      shadow_d    = value_in;
      shadow_dp_d = dp_in;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = disp_q[{dig_q, 2'b00} +: 4];
    upper     = disp_q >> {dig_q, 2'b00};
    lead_zero = (dig_q != '0) && (upper == 16'h0000);
    seg_d     = SEG_BLANK;
    dig_en_d  = DIG_BLANK;
    if (state_q == ST_SHOW) begin
      seg_d    = {(lzb_en && lead_zero) ? SEG_BLANK[7:1] : dec_seg[7:1], ~disp_dp_q[dig_q]};
      dig_en_d = DIG_BLANK & ~(4'b0001 << dig_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      state_q     <= ST_BLANK;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= 1'b0;
      seg_q       <= SEG_BLANK;
      dig_en_q    <= DIG_BLANK;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_out    = dig_en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4 at SCAN_DIV=16, BLANK_CYC=2: cycle model plus
// a table of expected per-digit segment patterns and directed boundary/reset cases.
module tb_seg7_scan4;

  localparam int SD = 16;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_we;
  logic        lzb_en;
  logic [7:0]  seg_out;
  logic [3:0]  dig_out;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .value_we   (value_we),
    .lzb_en     (lzb_en),
    .seg_out    (seg_out),
    .dig_out    (dig_out),
    .frame_tick (frame_tick)
  );

  logic [7:0] lut [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};

  int checks = 0;
  int errors = 0;

  // Reference model: position within the 64-clock frame plus display/shadow contents.
  int          m_pos;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend;
  int          tick_cnt;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            lzb;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [7:0]  es;
    logic [3:0]  ed;
    logic        et;
    logic [15:0] hi;
    int          sc, dg;
    sc = m_pos % SD;
    dg = (m_pos / SD) % 4;
    et = 1'b0;
    es = 8'hFF;
    ed = 4'hF;
    if (!rst && sc >= BC) begin
      hi = m_disp >> (4 * dg);
      es = (lzb_en && dg > 0 && hi == 16'h0) ? 8'hFF : lut[hi[3:0]];
      es[0] = ~m_dp[dg];
      ed[dg] = 1'b0;
    end
    if (rst) begin
      m_pos = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
    end else begin
      if (m_pos == FR - 1) begin
        if (value_we) begin
          m_disp = value_in; m_dp = dp_in; m_pend = 1'b0; et = 1'b1;
        end else if (m_pend) begin
          m_disp = m_sh; m_dp = m_shdp; m_pend = 1'b0; et = 1'b1;
        end
      end else if (value_we) begin
        m_sh = value_in; m_shdp = dp_in; m_pend = 1'b1;
      end
      m_pos = (m_pos + 1) % FR;
    end
    @(posedge clk);
    #1;
    chk("seg_out", 16'(seg_out), 16'(es));
    chk("dig_out", 16'(dig_out), 16'(ed));
    chk("frame_tick", 16'(frame_tick), 16'(et));
    if (frame_tick) tick_cnt++;
  endtask

  task automatic step_to(input int p);
    int n;
    n = 0;
    while (m_pos != p && n < FR) begin
      step();
      n++;
    end
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    value_we = 1'b1;
    step();
    value_we = 1'b0;
  endtask

  task automatic wait_frame_start(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 3 * FR);
    checks++;
    if (!frame_tick) begin
      errors++;
      $display("FAIL %s: frame_tick not seen within %0d cycles", name, n);
    end
  endtask

  // Runs one full frame from its first slot, recording the SHOW pattern per digit.
  task automatic capture(input int we_at, input logic [15:0] wv, output logic [3:0][7:0] cap);
    cap = '0;
    for (int i = 0; i < FR; i++) begin
      if (i == we_at) begin
        value_in = wv;
        dp_in    = 4'h0;
        value_we = 1'b1;
      end
      step();
      value_we = 1'b0;
      for (int k = 0; k < 4; k++)
        if (dig_out != 4'hF && !dig_out[k]) cap[k] = seg_out;
    end
  endtask

  task automatic chk_frame(input string name, input logic [3:0][7:0] cap, input logic [3:0][7:0] exp);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_dig%0d", name, k), 16'(cap[k]), 16'(exp[k]));
  endtask

  initial begin
    logic [3:0][7:0] cap;
    int t0;
    rst = 1'b1; value_we = 1'b0; value_in = '0; dp_in = '0; lzb_en = 1'b0;
    m_pos = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
    tick_cnt = 0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
    vecs[1] = '{16'hABCD, 4'b0000, 1'b0, {8'h11, 8'hC1, 8'hE5, 8'h85}};
    vecs[2] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h49, 8'h03}};
    vecs[3] = '{16'h0050, 4'b1000, 1'b1, {8'hFE, 8'hFF, 8'h49, 8'h03}};
    vecs[4] = '{16'h0001, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h9F}};
    vecs[5] = '{16'h0000, 4'b0001, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h02}};
    vecs[6] = '{16'h89EF, 4'b0101, 1'b0, {8'h01, 8'h08, 8'h61, 8'h70}};
    vecs[7] = '{16'h0567, 4'b0000, 1'b1, {8'hFF, 8'h49, 8'h41, 8'h1F}};
    vecs[8] = '{16'h1020, 4'b0000, 1'b1, {8'h9F, 8'h03, 8'h25, 8'h03}};

    step();
    step();
    chk("reset_seg", 16'(seg_out), 16'h00FF);
    chk("reset_dig", 16'(dig_out), 16'h000F);
    chk("reset_tick", 16'(frame_tick), 16'h0000);
    rst = 1'b0;

    capture(-1, 16'h0, cap);
    chk_frame("idle", cap, {8'h03, 8'h03, 8'h03, 8'h03});

    // Mid-frame write is held back until the boundary, then a single reload.
    step_to(20);
    t0 = tick_cnt;
    write(16'h1234, 4'h0);
    wait_frame_start("w1234");
    capture(-1, 16'h0, cap);
    chk_frame("w1234", cap, {8'h9F, 8'h25, 8'h0D, 8'h99});
    chk("w1234_tick_count", 16'(tick_cnt - t0), 16'd1);

    // Write on the boundary cycle loads directly; a later write waits a frame.
    step_to(FR - 1);
    write(16'hABCD, 4'h0);
    chk("bnd_tick", 16'(frame_tick), 16'h0001);
    capture(20, 16'h0001, cap);
    chk_frame("bnd_abcd", cap, {8'h11, 8'hC1, 8'hE5, 8'h85});
    chk("bnd_tick2", 16'(frame_tick), 16'h0001);
    capture(-1, 16'h0, cap);
    chk_frame("bnd_0001", cap, {8'h03, 8'h03, 8'h03, 8'h9F});

    for (int v = 0; v < 9; v++) begin
      lzb_en = vecs[v].lzb;
      step_to(10);
      write(vecs[v].val, vecs[v].dp);
      wait_frame_start($sformatf("vec%0d", v));
      capture(-1, 16'h0, cap);
      chk_frame($sformatf("vec%0d", v), cap, vecs[v].exp);
    end

    // Reset mid-slot of digit 2 with a write pending.
    lzb_en = 1'b0;
    step_to(3);
    write(16'h7777, 4'hF);
    step_to(2 * SD + 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_seg", 16'(seg_out), 16'h00FF);
    chk("rst_mid_dig", 16'(dig_out), 16'h000F);
    t0 = tick_cnt;
    step(); step(); step();
    chk("rst_restart_dig", 16'(dig_out), 16'h000E);
    chk("rst_restart_seg", 16'(seg_out), 16'h0003);
    repeat (FR - 3) step();
    chk("rst_no_reload", 16'(tick_cnt - t0), 16'd0);
    capture(-1, 16'h0, cap);
    chk_frame("rst_zero", cap, {8'h03, 8'h03, 8'h03, 8'h03});

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      value_we = (m_pos == FR - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
      value_in = r >> (4 * $urandom_range(0, 3));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      step();
    end
    rst = 1'b0;
    value_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
